// File: rtl/bp_resolve_queue_pkg.sv
// bp_resolve_queue_pkg: shared types for the branch prediction resolve queue
// Provides the address type, queued prediction record, predictor update record and FSM states.
package bp_pkg;
    typedef logic [31:0] addr_t;

    typedef struct packed {
        addr_t pc;
        logic  pred_taken;
        addr_t pred_target;
    } bp_entry_t;

    typedef struct packed {
        logic  write;
        addr_t pc;
        addr_t dest;
        logic  taken;
    } bp_update_t;

    typedef enum logic {RUN, RECOVER} state_t;
endpackage

// File: rtl/bp_resolve_queue_fifo.sv
// bp_fifo: circular buffer of prediction records with push/pop/clear
// Ports: clk, reset (async, active high); push/pop strobes; clear empties the buffer and wins
// over push/pop; din/dout carry records (dout is the head); count is the occupancy; full/empty.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = $bits(bp_entry_t)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[head_q];
    assign count   = count_q;

    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        head_d  = clear ? '0 : head_q + AW'(do_pop);
        tail_d  = clear ? '0 : tail_q + AW'(do_push);
        count_d = clear ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[tail_q] <= din;
    end
endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: checks fetch-time branch predictions against execute outcomes
// Ports: clk, reset (async, active high); push_* accept one prediction record per cycle from fetch;
// res_* resolve the oldest queued instruction; flush clears all in-flight state; bht_* is the
// registered predictor update; redirect/redirect_pc is the registered front-end redirect;
// count is the occupancy, mispredict_cnt counts redirects, underflow is sticky on resolve-when-empty.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_BITS       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [31:0]            push_pc,
    input  logic                   push_hit,
    input  logic                   push_dpre,
    input  logic [31:0]            push_target,
    input  logic                   res_valid,
    input  logic                   res_is_branch,
    input  logic                   res_taken,
    input  logic [31:0]            res_target,
    input  logic                   flush,
    output logic                   bht_write,
    output logic [31:0]            bht_pc,
    output logic [31:0]            bht_dest,
    output logic                   bht_taken,
    output logic                   redirect,
    output logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_BITS-1:0]    mispredict_cnt,
    output logic                   underflow
);
    localparam int RCW = $clog2(RECOVER_CYCLES + 1);

    state_t             state_q, state_d;
    logic [RCW-1:0]     rcnt_q, rcnt_d;
    bp_update_t         upd_q, upd_d;
    logic               redirect_q, redirect_d;
    addr_t              redirect_pc_q, redirect_pc_d;
    logic [CNT_BITS-1:0] mcnt_q, mcnt_d;
    logic               underflow_q, underflow_d;

    bp_entry_t head, push_entry;
    logic      full, empty, push_acc, resolve, taken_eff, mis;

    assign push_ready = !full && state_q == RUN;
    assign push_acc   = push_valid && push_ready;
    assign push_entry = '{pc: push_pc, pred_taken: push_hit & push_dpre, pred_target: push_target};
    assign resolve    = res_valid && !empty && !flush;
    // a non-branch behaves as an actual not-taken outcome
    assign taken_eff  = res_is_branch && res_taken;
    assign mis        = resolve && ((head.pred_taken != taken_eff) ||
                        (head.pred_taken && taken_eff && head.pred_target != res_target));

    bp_fifo #(.DEPTH(DEPTH), .W($bits(bp_entry_t))) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push_acc),
        .pop  (resolve),
        .clear(flush || mis),
        .din  (push_entry),
        .dout (head),
        .count(count),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        if (flush) state_d = RUN;
        else if (mis) begin
            state_d = RECOVER;
            rcnt_d  = RCW'(RECOVER_CYCLES - 1);
        end else if (state_q == RECOVER) begin
            if (rcnt_q == '0) state_d = RUN;
            else rcnt_d = rcnt_q - 1'b1;
        end
        upd_d         = resolve ? '{write: res_is_branch, pc: head.pc, dest: res_target, taken: res_taken}
                                : '{write: 1'b0, pc: upd_q.pc, dest: upd_q.dest, taken: upd_q.taken};
        redirect_d    = mis;
        redirect_pc_d = mis ? (taken_eff ? res_target : head.pc + 32'd4) : redirect_pc_q;
        mcnt_d        = mcnt_q + CNT_BITS'(mis);
        underflow_d   = underflow_q || (res_valid && empty && !flush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            rcnt_q        <= '0;
            upd_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            mcnt_q        <= '0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            upd_q         <= upd_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            mcnt_q        <= mcnt_d;
            underflow_q   <= underflow_d;
        end
    end

    assign bht_write      = upd_q.write;
    assign bht_pc         = upd_q.pc;
    assign bht_dest       = upd_q.dest;
    assign bht_taken      = upd_q.taken;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = mcnt_q;
    assign underflow      = underflow_q;
endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb_bp_resolve_queue: directed scoreboard bench for bp_resolve_queue
module tb_bp_resolve_queue;
    localparam int DEPTH = 8;
    localparam int RECOVER_CYCLES = 2;

    logic        clk = 0, reset = 1;
    logic        push_valid = 0, push_hit = 0, push_dpre = 0;
    logic [31:0] push_pc = 0, push_target = 0;
    logic        res_valid = 0, res_is_branch = 0, res_taken = 0, flush = 0;
    logic [31:0] res_target = 0;
    logic        push_ready, bht_write, bht_taken, redirect, underflow;
    logic [31:0] bht_pc, bht_dest, redirect_pc, mispredict_cnt;
    logic [3:0]  count;

    bp_resolve_queue #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER_CYCLES), .CNT_BITS(32)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_hit(push_hit), .push_dpre(push_dpre), .push_target(push_target),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
        .res_target(res_target), .flush(flush),
        .bht_write(bht_write), .bht_pc(bht_pc), .bht_dest(bht_dest), .bht_taken(bht_taken),
        .redirect(redirect), .redirect_pc(redirect_pc), .count(count),
        .mispredict_cnt(mispredict_cnt), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } exp_t;

    exp_t        sb[$];
    int          compared = 0, mismatched = 0;
    int          rec_left = 0;
    logic [31:0] m_cnt = 0;
    logic        m_uf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic pv, input logic [31:0] ppc, input logic ph, input logic pd,
                        input logic [31:0] ptg, input logic rv, input logic rb, input logic rt,
                        input logic [31:0] rtg, input logic fl);
        exp_t        e;
        logic        te, mis, rdy, ebw;
        logic [31:0] epc, erp;
        push_valid = pv; push_pc = ppc; push_hit = ph; push_dpre = pd; push_target = ptg;
        res_valid = rv; res_is_branch = rb; res_taken = rt; res_target = rtg; flush = fl;
        #1;
        rdy = sb.size() < DEPTH && rec_left == 0;
        chk("push_ready", {31'd0, push_ready}, {31'd0, rdy});
        mis = 0; ebw = 0; epc = 0; erp = 0;
        if (!fl && rv && sb.size() > 0) begin
            e   = sb.pop_front();
            te  = rb & rt;
            mis = (e.pt != te) || (e.pt && te && e.tgt != rtg);
            ebw = rb;
            epc = e.pc;
            erp = te ? rtg : e.pc + 32'd4;
        end else if (!fl && rv) m_uf = 1;
        if (fl || mis) sb.delete();
        else if (pv && rdy) sb.push_back('{ppc, ph & pd, ptg});
        if (mis) m_cnt++;
        @(posedge clk); #1;
        if (rec_left > 0) rec_left--;
        if (fl) rec_left = 0;
        if (mis) rec_left = RECOVER_CYCLES;
        push_valid = 0; res_valid = 0; flush = 0;
        chk("bht_write", {31'd0, bht_write}, {31'd0, ebw});
        if (ebw) begin
            chk("bht_pc", bht_pc, epc);
            chk("bht_dest", bht_dest, rtg);
            chk("bht_taken", {31'd0, bht_taken}, {31'd0, rt});
        end
        chk("redirect", {31'd0, redirect}, {31'd0, mis});
        if (mis) chk("redirect_pc", redirect_pc, erp);
        chk("count", {28'd0, count}, sb.size());
        chk("mispredict_cnt", mispredict_cnt, m_cnt);
        chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
    endtask

    task automatic push_only(input logic [31:0] pc, input logic h, input logic d, input logic [31:0] t);
        step(1, pc, h, d, t, 0, 0, 0, 0, 0);
    endtask

    task automatic res_only(input logic b, input logic t, input logic [31:0] tg);
        step(0, 0, 0, 0, 0, 1, b, t, tg, 0);
    endtask

    task automatic check_zero();
        chk("rst_bht_write", {31'd0, bht_write}, 0);
        chk("rst_bht_pc", bht_pc, 0);
        chk("rst_bht_dest", bht_dest, 0);
        chk("rst_bht_taken", {31'd0, bht_taken}, 0);
        chk("rst_redirect", {31'd0, redirect}, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_count", {28'd0, count}, 0);
        chk("rst_mispredict_cnt", mispredict_cnt, 0);
        chk("rst_underflow", {31'd0, underflow}, 0);
        chk("rst_push_ready", {31'd0, push_ready}, 1);
    endtask

    initial begin
        #2;
        check_zero();
        @(negedge clk); @(negedge clk);
        reset = 0;
        @(posedge clk); #1;

        // correctly predicted taken branch
        push_only(32'h1000, 1, 1, 32'h2000);
        res_only(1, 1, 32'h2000);

        // miss predicted not-taken, then recovery window drops pushes
        push_only(32'h1000, 0, 0, 32'h0);
        res_only(1, 1, 32'h3000);
        push_only(32'h1111, 0, 0, 0);
        push_only(32'h2222, 0, 0, 0);
        push_only(32'h1004, 0, 0, 0);
        res_only(1, 0, 32'h0);

        // wrong target, then not-taken wrap of pc+4
        push_only(32'h1100, 1, 1, 32'h2000);
        res_only(1, 1, 32'h2400);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_only(32'hFFFF_FFFC, 1, 1, 32'h10);
        res_only(1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // fill, full with simultaneous pop, then wrap through 20 resolves
        for (int i = 0; i < DEPTH; i++) push_only(32'h4000 + 32'(i) * 4, 0, 0, 0);
        step(1, 32'h5000, 0, 0, 0, 1, 1, 0, 32'h0, 0);
        for (int i = 0; i < 20; i++) step(1, 32'h6000 + 32'(i) * 4, 0, 1, 0, 1, 1, 0, 32'h0, 0);
        for (int i = 0; i < DEPTH - 1; i++) res_only(1, 0, 32'h0);

        // non-branch resolve against a predicted-taken entry redirects to pc+4
        push_only(32'h7000, 1, 1, 32'h7100);
        res_only(0, 1, 32'h7100);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // mispredicting resolve coinciding with flush and a push
        push_only(32'h8000, 0, 0, 0);
        push_only(32'h8004, 0, 0, 0);
        step(1, 32'h8008, 0, 0, 0, 1, 1, 1, 32'h9000, 1);
        push_only(32'h800C, 0, 0, 0);
        res_only(1, 0, 32'h0);

        // underflow is sticky
        res_only(1, 1, 32'h1234);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // async reset mid-stream
        push_only(32'hA000, 0, 0, 0);
        push_only(32'hA004, 0, 0, 0);
        #3;
        reset = 1;
        #1;
        check_zero();
        sb.delete(); m_cnt = 0; m_uf = 0; rec_left = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        push_only(32'hB000, 1, 1, 32'hB800);
        res_only(1, 1, 32'hB800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
Execute-side counterpart of the fetch-stage branch target/direction predictor. It buffers every prediction issued at fetch in program order. It checks each prediction against the actual outcome resolved at execute. It generates the predictor update (write enable, branch pc, destination, taken) and a registered front-end redirect on mispredict. Sits between the F1 predictor lookup, the execute branch unit and the PC-select logic.

Parameters:
DEPTH, 8, prediction queue entries (power of two, >=2)
RECOVER_CYCLES, 2, cycles pushes are dropped after a redirect (wrong-path drain)
CNT_BITS, 32, width of mispredict statistics counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
push_valid  in  1  fetch issues one prediction record this cycle
push_ready  out  1  queue accepts push (combinational: ~full && state==RUN)
push_pc  in  32  pc of fetched instruction
push_hit  in  1  predictor hit for push_pc
push_dpre  in  1  predicted direction (counter MSB)
push_target  in  32  predicted target
res_valid  in  1  execute resolves the oldest queued instruction
res_is_branch  in  1  resolved instruction is a control transfer
res_taken  in  1  actual direction
res_target  in  32  actual destination
flush  in  1  exception/eret flush from commit; clears everything
bht_write  out  1  registered predictor write strobe
bht_pc  out  32  executed branch pc
bht_dest  out  32  actual destination
bht_taken  out  1  actual direction
redirect  out  1  registered one-cycle redirect pulse
redirect_pc  out  32  correct next pc
count  out  $clog2(DEPTH)+1  occupancy
mispredict_cnt  out  CNT_BITS  wrapping count of redirects
underflow  out  1  sticky: res_valid with empty queue

Behaviour:
- Reset (async): head/tail/count=0, state=RUN, all outputs 0, mispredict_cnt=0, underflow=0.
- Entry = {pc, pred_taken = hit & dpre, pred_target}. Push accepted iff push_valid & push_ready; written at tail, tail wraps modulo DEPTH.
- Full: push_ready=0 even if a pop happens the same cycle (no bypass). Pop and push in same cycle when not full: count unchanged.
- Resolve: res_valid with count>0 pops head same edge. Mispredict iff pred_taken!=res_taken, or both taken and pred_target!=res_target. For non-branch, res_taken treated as 0.
- Update, registered one cycle after resolve: bht_write=res_is_branch, bht_pc=head pc, bht_dest=res_target, bht_taken=res_taken. Strobes last exactly one cycle.
- Mispredict, next cycle: redirect=1, redirect_pc = res_taken ? res_target : pc+4 (mod 2^32). mispredict_cnt increments, wraps to 0. Same edge: queue cleared (head=tail, count=0); any simultaneous push is discarded. State -> RECOVER.
- FSM RUN: normal. RECOVER: push_ready=0, down-counter loaded RECOVER_CYCLES-1, return to RUN when it reaches 0. A new mispredict cannot occur in RECOVER (queue empty); res_valid there sets underflow.
- res_valid with count==0: no pop, no update, no redirect, underflow<=1 (sticky until reset).
- flush: highest priority. Clears queue, state->RUN, suppresses push/resolve effects and any redirect that cycle. Does not clear mispredict_cnt/underflow. Update strobes from the flush cycle are suppressed.
- Reset mid-operation: immediate clear irrespective of clock.

Decomposition:
- Package bp_pkg: addr_t, bp_entry_t {pc, pred_taken, pred_target}, bp_update_t {write, pc, dest, taken}, state enum {RUN, RECOVER}.
- One sub-module: bp_fifo (parameterised circular buffer with push/pop/clear, count, full/empty); FSM, compare and output registers in top.

Test Plan:
- Push pc 0x1000 hit=1 dpre=1 target 0x2000; resolve taken, target 0x2000 -> next cycle bht_write=1, bht_pc=0x1000, bht_taken=1, redirect=0.
- Push pc 0x1000 hit=0; resolve taken to 0x3000 -> redirect=1, redirect_pc=0x3000, mispredict_cnt=1, count=0, push_ready=0 for 2 cycles then 1.
- Push hit=1 dpre=1 target 0x2000, resolve taken to 0x2400 -> redirect_pc=0x2400; resolve not-taken pc 0xFFFFFFFC predicted taken -> redirect_pc=0x00000000.
- Fill 8 entries -> push_ready=0, count=8; simultaneous push+pop -> push dropped, count=7; tail wrap verified by 20 in-order resolves with matching bht_pc.
- Mispredicting resolve and flush in same cycle -> no redirect, no bht_write, count=0, state RUN.
- res_valid on empty queue -> underflow=1 persists; async reset mid-stream -> all outputs 0 without a clock edge.
